// File: rtl/delay_pkg.sv
// Shared types and constants for the multi-channel delay/period timer.
package delay_pkg;

    localparam int unsigned DLY_CBITS = 17;

    typedef enum logic {ST_IDLE, ST_RUN} dly_state_t;
    typedef enum logic {MODE_ONESHOT, MODE_PERIODIC} dly_mode_t;

    // Channel-select width; a single-channel build still gets a 1-bit select.
    function automatic int unsigned ch_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_delay_timer_if.sv
// Config handshake plus per-channel control/status bundle of the delay timer.
interface multi_delay_timer_if
    import delay_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CBITS = DLY_CBITS
);
    localparam int unsigned CHW = ch_bits(NCH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CHW-1:0]   cfg_ch;
    logic [CBITS-1:0] cfg_period;
    logic             cfg_mode;
    logic [NCH-1:0]   start;
    logic [NCH-1:0]   stop;
    logic [NCH-1:0]   sig;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   err;
    logic [NCH-1:0]   err_clr;

    modport master (
        output cfg_valid, cfg_ch, cfg_period, cfg_mode, start, stop, err_clr,
        input  cfg_ready, sig, busy, err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_period, cfg_mode, start, stop, err_clr,
        output cfg_ready, sig, busy, err
    );
endinterface

// File: rtl/delay_chan.sv
// One timer channel: IDLE/RUN FSM, counter, active period/mode and a shadow
// config slot that a running channel adopts only when its count wraps.
module delay_chan
    import delay_pkg::*;
#(
    parameter int unsigned CBITS      = DLY_CBITS,
    parameter int unsigned DEF_PERIOD = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             wr,
    input  logic [CBITS-1:0] wr_period,
    input  logic             wr_mode,
    output logic             sig,
    output logic             busy,
    output logic             overrun_c
);

    dly_state_t       state_q, state_d;
    dly_mode_t        mode_q, mode_d, shadow_mode_q, shadow_mode_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [CBITS-1:0] period_q, period_d;
    logic [CBITS-1:0] shadow_period_q, shadow_period_d;
    logic             pend_q, pend_d;
    logic             sig_q, sig_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            period_q        <= CBITS'(DEF_PERIOD);
            mode_q          <= MODE_PERIODIC;
            shadow_period_q <= CBITS'(DEF_PERIOD);
            shadow_mode_q   <= MODE_PERIODIC;
            pend_q          <= 1'b0;
            sig_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            period_q        <= period_d;
            mode_q          <= mode_d;
            shadow_period_q <= shadow_period_d;
            shadow_mode_q   <= shadow_mode_d;
            pend_q          <= pend_d;
            sig_q           <= sig_d;
        end
    end

    // Next state: stop > start > count; a write arriving on the wrap edge is adopted directly
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        period_d        = period_q;
        mode_d          = mode_q;
        shadow_period_d = shadow_period_q;
        shadow_mode_d   = shadow_mode_q;
        pend_d          = pend_q;
        sig_d           = 1'b0;
        overrun_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr) begin
                    period_d = wr_period;
                    mode_d   = dly_mode_t'(wr_mode);
                end
                if (start && !stop) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                overrun_c = start && !stop;
                if (stop || cnt_q == period_q) begin
                    cnt_d  = '0;
                    pend_d = 1'b0;
                    if (wr) begin
                        period_d = wr_period;
                        mode_d   = dly_mode_t'(wr_mode);
                    end else if (pend_q) begin
                        period_d = shadow_period_q;
                        mode_d   = shadow_mode_q;
                    end
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else begin
                        sig_d = 1'b1;
                        if (mode_q == MODE_ONESHOT) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CBITS'(1);
                    if (wr) begin
                        shadow_period_d = wr_period;
                        shadow_mode_d   = dly_mode_t'(wr_mode);
                        pend_d          = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sig  = sig_q;
    assign busy = (state_q == ST_RUN);

    cnt_within_period: assert property (@(posedge clk) disable iff (rst) cnt_q <= period_q);

    periodic_fires: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_RUN && mode_q == MODE_PERIODIC && cnt_q == period_q && !stop) |=> sig_q);

endmodule

// File: rtl/multi_delay_timer.sv
// NCH-channel programmable delay/period generator: config handshake, channel
// decode and the sticky per-channel error bank around delay_chan instances.
module multi_delay_timer
    import delay_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CBITS      = DLY_CBITS,
    parameter int unsigned DEF_PERIOD = 100000
) (
    input  logic                clk,
    input  logic                rst,
    multi_delay_timer_if.slave  bus
);

    localparam int unsigned CHW = ch_bits(NCH);

    logic           hold_q;
    logic [NCH-1:0] err_q;
    logic           cfg_ready_c;
    logic           cfg_xfer_c;
    logic           cfg_zero_c;
    logic [NCH-1:0] wr_c;
    logic [NCH-1:0] cfg_err_c;
    logic [NCH-1:0] overrun_c;
    logic [NCH-1:0] sig_w;
    logic [NCH-1:0] busy_w;

    // Ready is held low during reset and for one cycle after each accepted write
    assign cfg_ready_c = !rst && !hold_q;
    assign cfg_xfer_c  = bus.cfg_valid && cfg_ready_c;
    assign cfg_zero_c  = (bus.cfg_period == '0);

    always_comb begin
        wr_c      = '0;
        cfg_err_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cfg_xfer_c && bus.cfg_ch == CHW'(i)) begin
                if (cfg_zero_c) begin
                    cfg_err_c[i] = 1'b1;
                end else begin
                    wr_c[i] = 1'b1;
                end
            end
        end
    end

    // Handshake throttle and sticky errors (set wins over clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= 1'b0;
            err_q  <= '0;
        end else begin
            hold_q <= cfg_xfer_c;
            err_q  <= (err_q & ~bus.err_clr) | overrun_c | cfg_err_c;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        delay_chan #(
            .CBITS      (CBITS),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .start     (bus.start[i]),
            .stop      (bus.stop[i]),
            .wr        (wr_c[i]),
            .wr_period (bus.cfg_period),
            .wr_mode   (bus.cfg_mode),
            .sig       (sig_w[i]),
            .busy      (busy_w[i]),
            .overrun_c (overrun_c[i])
        );
    end

    assign bus.cfg_ready = cfg_ready_c;
    assign bus.sig       = sig_w;
    assign bus.busy      = busy_w;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_multi_delay_timer.sv
// Bench for multi_delay_timer: deadline-based reference model compared every
// cycle, plus directed scenarios with literal pulse-timing expectations.
module tb_multi_delay_timer;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CBITS = 17;
    localparam int unsigned DEF   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_delay_timer_if #(.NCH(NCH), .CBITS(CBITS)) bus ();

    multi_delay_timer #(.NCH(NCH), .CBITS(CBITS), .DEF_PERIOD(DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: each running channel carries the absolute edge number of its next pulse
    int          n = 0;
    bit          m_run  [NCH];
    int          m_fire [NCH];
    int          m_per  [NCH];
    bit          m_mode [NCH];
    bit          m_pend [NCH];
    int          m_shp  [NCH];
    bit          m_shm  [NCH];
    bit [NCH-1:0] m_sig;
    bit [NCH-1:0] m_err;
    bit          m_hold;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, n);
        else passed++;
    endtask

    task automatic take_cfg(input int c, input bit wr);
        if (wr) begin
            m_per[c]  = int'(bus.cfg_period);
            m_mode[c] = bus.cfg_mode;
        end else if (m_pend[c]) begin
            m_per[c]  = m_shp[c];
            m_mode[c] = m_shm[c];
        end
        m_pend[c] = 1'b0;
    endtask

    task automatic model_step();
        bit           xfer;
        bit           hit;
        bit           wr;
        bit           periodic;
        bit [NCH-1:0] set;
        n++;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_run[c] = 0; m_per[c] = DEF; m_mode[c] = 1; m_pend[c] = 0;
            end
            m_sig = '0; m_err = '0; m_hold = 0;
            return;
        end
        xfer = bus.cfg_valid && !m_hold;
        set  = '0;
        for (int c = 0; c < NCH; c++) begin
            hit = xfer && (int'(bus.cfg_ch) == c);
            wr  = hit && (bus.cfg_period != 0);
            if (hit && bus.cfg_period == 0) set[c] = 1'b1;
            m_sig[c] = 1'b0;
            if (m_run[c]) begin
                if (bus.start[c] && !bus.stop[c]) set[c] = 1'b1;
                if (bus.stop[c]) begin
                    m_run[c] = 0;
                    take_cfg(c, wr);
                end else if (n == m_fire[c]) begin
                    periodic = m_mode[c];
                    m_sig[c] = 1'b1;
                    take_cfg(c, wr);
                    if (periodic) m_fire[c] = n + m_per[c] + 1;
                    else          m_run[c]  = 0;
                end else if (wr) begin
                    m_pend[c] = 1'b1;
                    m_shp[c]  = int'(bus.cfg_period);
                    m_shm[c]  = bus.cfg_mode;
                end
            end else begin
                if (wr) begin
                    m_per[c]  = int'(bus.cfg_period);
                    m_mode[c] = bus.cfg_mode;
                end
                if (bus.start[c] && !bus.stop[c]) begin
                    m_run[c]  = 1;
                    m_fire[c] = n + m_per[c] + 1;
                end
            end
        end
        m_err  = (m_err & ~bus.err_clr) | set;
        m_hold = xfer;
    endtask

    task automatic compare();
        logic [NCH-1:0] run_v;
        for (int c = 0; c < NCH; c++) run_v[c] = m_run[c];
        chk("model_sig",   32'(bus.sig),       32'(m_sig));
        chk("model_busy",  32'(bus.busy),      32'(run_v));
        chk("model_err",   32'(bus.err),       32'(m_err));
        chk("model_ready", 32'(bus.cfg_ready), 32'(!rst && !m_hold));
    endtask

    // One clock: model consumes the driven inputs, DUT samples them, outputs compared mid-cycle
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic wr_cfg(input int c, input int p, input bit m);
        bus.cfg_valid  = 1'b1;
        bus.cfg_ch     = 2'(c);
        bus.cfg_period = CBITS'(p);
        bus.cfg_mode   = m;
        tick();
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic pulse_start(input int c);
        bus.start[c] = 1'b1;
        tick();
        bus.start = '0;
    endtask

    task automatic pulse_stop(input int c);
        bus.stop[c] = 1'b1;
        tick();
        bus.stop = '0;
    endtask

    logic [31:0] obs;
    logic        busy_all;

    initial begin
        bus.cfg_valid = 0; bus.cfg_ch = '0; bus.cfg_period = '0; bus.cfg_mode = 0;
        bus.start = '0; bus.stop = '0; bus.err_clr = '0;

        // Reset for two cycles, then defaults
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_sig",   32'(bus.sig),       32'h0);
        chk("rst_busy",  32'(bus.busy),      32'h0);
        chk("rst_err",   32'(bus.err),       32'h0);
        chk("rst_ready", 32'(bus.cfg_ready), 32'h1);

        // Periodic P=3 on ch0: pulses at E4, E8, E12
        wr_cfg(0, 3, 1); tick();
        pulse_start(0);
        obs = '0; busy_all = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            obs[k-1] = bus.sig[0];
            busy_all &= bus.busy[0];
        end
        chk("periodic_pulses", obs, 32'h888);
        chk("periodic_busy", 32'(busy_all), 32'h1);
        pulse_stop(0);
        chk("stop_idle", 32'(bus.busy[0]), 32'h0);

        // One-shot P=2 on ch1: single pulse at E3
        wr_cfg(1, 2, 0); tick();
        pulse_start(1);
        obs = '0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            obs[k-1] = bus.sig[1];
        end
        chk("oneshot_pulse", obs, 32'h4);
        chk("oneshot_busy_after", 32'(bus.busy[1]), 32'h0);

        // Reconfig while running: P=10 -> P=4 written at cnt=6
        wr_cfg(2, 10, 1); tick();
        pulse_start(2);
        obs = '0;
        for (int k = 1; k <= 21; k++) begin
            if (k == 7) begin
                bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_period = CBITS'(4); bus.cfg_mode = 1'b1;
            end
            tick();
            bus.cfg_valid = 1'b0;
            obs[k-1] = bus.sig[2];
        end
        chk("reconfig_pulses", obs, 32'h0010_8400);
        pulse_stop(2);

        // Overrun error on ch3, sticky, clear, set-beats-clear
        wr_cfg(3, 20, 1); tick();
        pulse_start(3);
        tick(); tick();
        pulse_start(3);
        chk("overrun_set", 32'(bus.err[3]), 32'h1);
        tick(); tick(); tick();
        chk("overrun_sticky", 32'(bus.err[3]), 32'h1);
        bus.err_clr[3] = 1'b1; tick(); bus.err_clr = '0;
        chk("err_clear", 32'(bus.err[3]), 32'h0);
        bus.start[3] = 1'b1; bus.err_clr[3] = 1'b1; tick(); bus.start = '0; bus.err_clr = '0;
        chk("set_beats_clear", 32'(bus.err[3]), 32'h1);
        bus.err_clr[3] = 1'b1; tick(); bus.err_clr = '0;
        pulse_stop(3);

        // Zero period write: error set, ch1 keeps its one-shot P=2
        wr_cfg(1, 0, 1);
        chk("zero_period_err", 32'(bus.err[1]), 32'h1);
        tick();
        pulse_start(1);
        obs = '0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            obs[k-1] = bus.sig[1];
        end
        chk("zero_period_unchanged", obs, 32'h4);
        bus.err_clr[1] = 1'b1; tick(); bus.err_clr = '0;
        chk("zero_err_clear", 32'(bus.err[1]), 32'h0);

        // Stop coincident with terminal count
        wr_cfg(0, 3, 1); tick();
        pulse_start(0);
        tick(); tick(); tick();
        pulse_stop(0);
        chk("stop_at_terminal_sig",  32'(bus.sig[0]),  32'h0);
        chk("stop_at_terminal_busy", 32'(bus.busy[0]), 32'h0);

        // Reset at cnt=P
        pulse_start(0);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("ready_in_reset", 32'(bus.cfg_ready), 32'h0);
        tick();
        chk("reset_at_terminal_sig",  32'(bus.sig[0]),  32'h0);
        chk("reset_at_terminal_busy", 32'(bus.busy[0]), 32'h0);
        rst = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 399) == 0);
            bus.cfg_valid  = ($urandom_range(0, 2) == 0);
            bus.cfg_ch     = 2'($urandom_range(0, NCH - 1));
            bus.cfg_period = CBITS'($urandom_range(0, 9));
            bus.cfg_mode   = 1'($urandom_range(0, 1));
            for (int c = 0; c < NCH; c++) begin
                bus.start[c]   = ($urandom_range(0, 11) == 0);
                bus.stop[c]    = ($urandom_range(0, 31) == 0);
                bus.err_clr[c] = ($urandom_range(0, 15) == 0);
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
